jtag_bus_sequencer: RTL and testbench
=====================================

# jtag_bus_sequencer

Command sequencer that turns 16-bit USER1 DR scans into single read/write transactions on a small register bus. It sits between the TAP-tracking logic around the Intel JTAG primitive and on-chip register slaves. It owns the USER1 DR shift register, and it sequences and times out each bus transaction. The JTAG host polls completion, error and read data through the Capture-DR frame.

## Interface
- ADDR_W, 7, register-bus address width; the DR frame assumes 7.
- DATA_W, 8, register-bus data width; the DR frame assumes 8.
- TIMEOUT, 15, TCK cycles bus_req may stay high without bus_ack; must be 1..255.

Ports:
- tckutap  in  1  only clock; user-TAP TCK from the JTAG primitive.
- reset  in  1  asynchronous, active-high; tie to Test-Logic-Reset decode or power-on.
- usr1user  in  1  USER1 selected; when 0, every strobe below is ignored.
- captureuser  in  1  Capture-DR strobe, already qualified by USER IR.
- shiftuser  in  1  Shift-DR strobe.
- updateuser  in  1  Update-DR strobe, already qualified by USER IR.
- tdiutap  in  1  TDI from the primitive.
- tdouser  out  1  TDO to the primitive.
- busy  out  1  transaction outstanding.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  DATA_W  write data.
- bus_ack  in  1  slave completion, sampled on posedge.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.

## Operation
- The 16-bit shift register `sr` shifts LSB first: sr <= {tdiutap, sr[15:1]} when usr1user and shiftuser are both high.
- Command frame at Update: [7:0] data, [14:8] addr, [15] wr.
- Capture frame loaded into `sr` at Capture:
  - [7:0] last read data
  - [8] busy
  - [9] err
  - [10] overrun
  - [14:11] seq, the completed-transaction count mod 16
  - [15] constant 1, used as a presence marker
- If captureuser and shiftuser are both high on the same edge, capture wins.
- FSM states are IDLE and REQ.
  - IDLE: updateuser with usr1user → latch addr, wdata and wr into the bus_* registers, clear the wait counter, go to REQ.
  - REQ: bus_req=1 and busy=1; the wait counter increments each cycle.
    - On bus_ack: if bus_we=0, latch bus_rdata into rdata; seq+1; go to IDLE.
    - If the wait counter reaches TIMEOUT without ack: set err, leave rdata and seq unchanged, go to IDLE.
    - If ack and timeout occur on the same edge, ack wins.
- updateuser in REQ: the command is discarded, overrun is set, and the bus_* registers are unchanged.
- err and overrun are sticky. Both clear on the capture edge that loads them into `sr`.
  - A flag set on that same edge survives.
  - Set has priority over clear.
- seq wraps from 15 to 0.
- bus_addr and bus_wdata hold their last values in IDLE.
- bus_we is valid only while bus_req is high.

## Timing
- Reset (asynchronous) sets:
  - FSM to IDLE
  - bus_req, bus_we, busy to 0
  - bus_addr, bus_wdata to 0
  - rdata, seq, err, overrun to 0
  - sr and the wait counter to 0
  - tdouser to 0
- Reset mid-transaction drops bus_req immediately. No completion is recorded.
- Update sampled at posedge N → bus_req=1 after posedge N (visible during cycle N+1).
- bus_ack sampled at posedge M → bus_req=0 after posedge M. rdata and seq update at M.
- Minimum transaction: bus_req is high for 1 cycle, when ack arrives on the first sampling edge.
- Timeout: bus_req is high for exactly TIMEOUT cycles, then drops. err is readable on the next capture.
- A capture on the same edge as an ack frames the pre-ack values: busy=1, old seq.
- tdouser <= sr[0] on negedge tckutap when usr1user=1, else 0. This is the only negedge flop.
- TCK runs only during JTAG activity. The host must clock Run-Test/Idle cycles while waiting for completion, then poll busy.

## Test plan
- **Write.** After reset, scan in 0x8A5C and Update. Required:
  - bus_req=1, bus_we=1, bus_addr=0x0A, bus_wdata=0x5C on the next cycle.
  - With ack on the 3rd cycle, bus_req drops.
  - Next capture shifts out 0x8800.
- **Read.** Scan in 0x0300 and Update. Slave acks with bus_rdata=0xC3 after 2 cycles. Required:
  - Next capture frame = 0x90C3 (seq=2).
  - bus_we=0 throughout the transaction.
- **Timeout.** TIMEOUT=15 and no ack. Required:
  - bus_req is high for exactly 15 cycles.
  - Next capture = 0x9200 + rdata (err set).
  - The following capture has err cleared.
- **Overrun.** Issue a second Update (0x8177) while in REQ. Required:
  - bus_addr and bus_wdata are unchanged.
  - After ack, capture shows overrun (bit 10) and seq incremented by 1 only.
- **Deselected.** With usr1user=0, pulse capture, shift and update with arbitrary TDI. Required:
  - sr, FSM and bus outputs are unchanged.
  - tdouser=0.
- **Reset mid-transaction.** Assert reset in REQ between clock edges. Required:
  - bus_req and busy go to 0 asynchronously.
  - After release, capture = 0x8000.

Source files
------------

// File: rtl/jtag_bus_sequencer_if.sv
// Register-bus connection between jtag_bus_sequencer (master) and a register
// slave. One request/acknowledge transaction at a time.
//   bus_req   : transaction request, held until bus_ack or timeout
//   bus_we    : 1 = write, valid only while bus_req is high
//   bus_addr  : transaction address
//   bus_wdata : write data
//   bus_ack   : slave completion, sampled on the rising clock edge
//   bus_rdata : read data, valid together with bus_ack
interface jtag_bus_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/jtag_bus_sequencer.sv
// Turns 16-bit USER1 DR scans into single register-bus transactions.
// Owns the USER1 DR shift register, runs a two-state request FSM with a
// wait-cycle timeout, and reports status through the Capture-DR frame.
// Ports:
//   tckutap     : only clock (user-TAP TCK)
//   reset       : asynchronous active-high reset
//   usr1user    : USER1 selected; gates every strobe
//   captureuser : Capture-DR strobe
//   shiftuser   : Shift-DR strobe
//   updateuser  : Update-DR strobe
//   tdiutap     : TDI in
//   tdouser     : TDO out, updated on the falling edge
//   busy        : transaction outstanding
//   bus         : register-bus master side
// Command frame : [15] wr, [14:8] addr, [7:0] data.
// Capture frame : [15] 1, [14:11] seq, [10] overrun, [9] err, [8] busy,
//                 [7:0] last read data.
module jtag_bus_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic tckutap,
  input  logic reset,
  input  logic usr1user,
  input  logic captureuser,
  input  logic shiftuser,
  input  logic updateuser,
  input  logic tdiutap,
  output logic tdouser,
  output logic busy,
  jtag_bus_sequencer_if.master bus
);

  typedef enum logic {IDLE, REQ} state_t;

  // Last wait-counter value before the timeout edge: bus_req stays high for
  // exactly TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [15:0]       sr;
  logic [7:0]        wait_cnt;
  logic              req_reg;
  logic              we_reg;
  logic              busy_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [3:0]        seq_reg;
  logic              err_reg;
  logic              ovr_reg;

  logic cap, sh, upd;
  logic ack_hit, timeout_hit, ovr_set;
  logic [15:0] frame;

  assign cap = usr1user & captureuser;
  assign sh  = usr1user & shiftuser;
  assign upd = usr1user & updateuser;

  // Ack wins over a timeout falling on the same edge.
  assign ack_hit     = (state == REQ) & bus.bus_ack;
  assign timeout_hit = (state == REQ) & ~bus.bus_ack & (wait_cnt == WAIT_LAST);
  assign ovr_set     = (state == REQ) & upd;

  assign frame = {1'b1, seq_reg, ovr_reg, err_reg, busy_reg, rdata_reg};

  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      wait_cnt  <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      seq_reg   <= '0;
      err_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      // Capture beats shift on the same edge.
      if (cap) begin
        sr <= frame;
      end else if (sh) begin
        sr <= {tdiutap, sr[15:1]};
      end

      // Sticky flags: a capture clears them, a set on that edge survives.
      err_reg <= timeout_hit | (err_reg & ~cap);
      ovr_reg <= ovr_set | (ovr_reg & ~cap);

      case (state)
        IDLE: begin
          if (upd) begin
            addr_reg  <= sr[14:8];
            wdata_reg <= sr[7:0];
            we_reg    <= sr[15];
            wait_cnt  <= '0;
            req_reg   <= 1'b1;
            busy_reg  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_hit) begin
            if (!we_reg) begin
              rdata_reg <= bus.bus_rdata;
            end
            seq_reg  <= seq_reg + 4'd1;
            req_reg  <= 1'b0;
            we_reg   <= 1'b0;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            req_reg  <= 1'b0;
            we_reg   <= 1'b0;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // TDO changes on the falling edge so the host samples it stable.
  always_ff @(negedge tckutap or posedge reset) begin
    if (reset) begin
      tdouser <= 1'b0;
    end else begin
      tdouser <= usr1user ? sr[0] : 1'b0;
    end
  end

  assign busy          = busy_reg;
  assign bus.bus_req   = req_reg;
  assign bus.bus_we    = we_reg;
  assign bus.bus_addr  = addr_reg;
  assign bus.bus_wdata = wdata_reg;

endmodule

// File: tb/tb_jtag_bus_sequencer.sv
module tb_jtag_bus_sequencer;
  localparam int TIMEOUT = 15;

  logic tckutap = 1'b0;
  logic reset, usr1user, captureuser, shiftuser, updateuser, tdiutap;
  logic tdouser, busy;

  jtag_bus_sequencer_if bif ();

  jtag_bus_sequencer #(.ADDR_W(7), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .tckutap     (tckutap),
    .reset       (reset),
    .usr1user    (usr1user),
    .captureuser (captureuser),
    .shiftuser   (shiftuser),
    .updateuser  (updateuser),
    .tdiutap     (tdiutap),
    .tdouser     (tdouser),
    .busy        (busy),
    .bus         (bif)
  );

  always #5 tckutap = ~tckutap;

  int checks = 0;
  int passed = 0;

  // Transaction-level reference model.
  bit          m_busy;
  logic [15:0] m_cmd;
  int          m_len;
  bit          m_ok;
  int          m_elapsed;
  logic [3:0]  m_seq;
  logic [7:0]  m_rdata;
  bit          m_err, m_ovr;
  logic [15:0] m_frame;

  // Slave model.
  int          s_delay;
  logic [7:0]  s_rdata;
  int          s_len;
  bit          prev_req;

  typedef struct {
    logic [15:0] cmd;
    bit          do_upd;
    int          delay;
    logic [7:0]  rd;
    logic [15:0] exp_frame;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_cmd = '0; m_len = 0; m_ok = 0; m_elapsed = 0;
    m_seq = '0; m_rdata = '0; m_err = 0; m_ovr = 0;
    s_delay = 0; s_rdata = '0; s_len = 0; prev_req = 0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
  endtask

  // Advance to just after the falling edge; update model, slave and checks.
  task automatic tick();
    @(negedge tckutap);
    #1;
    if (m_busy) begin
      m_elapsed++;
      if (m_elapsed > m_len) begin
        if (m_ok) begin
          m_seq = m_seq + 4'd1;
          if (!m_cmd[15]) m_rdata = s_rdata;
        end else begin
          m_err = 1;
        end
        m_busy = 0;
      end
    end
    check(bif.bus_req === m_busy && busy === m_busy, "req_busy",
          {bif.bus_req, busy}, {m_busy, m_busy});
    if (bif.bus_req && m_busy)
      check(bif.bus_we === m_cmd[15] && bif.bus_addr === m_cmd[14:8] && bif.bus_wdata === m_cmd[7:0],
            "bus_fields", {bif.bus_we, bif.bus_addr, bif.bus_wdata}, m_cmd);
    if (!usr1user) check(tdouser === 1'b0, "tdo_deselected", tdouser, 0);
    if (bif.bus_req) begin
      s_len = prev_req ? s_len + 1 : 1;
      bif.bus_ack = (s_len == s_delay);
      bif.bus_rdata = bif.bus_ack ? s_rdata : ~s_rdata;
    end else begin
      bif.bus_ack = 1'b0;
    end
    prev_req = bif.bus_req;
  endtask

  task automatic issue_update(input logic [15:0] cmd, input int delay, input logic [7:0] rd);
    updateuser = 1'b1;
    if (m_busy) begin
      m_ovr = 1;
    end else begin
      m_busy = 1; m_cmd = cmd; m_elapsed = 0;
      m_ok = (delay >= 1 && delay <= TIMEOUT);
      m_len = m_ok ? delay : TIMEOUT;
      s_delay = delay; s_rdata = rd;
    end
  endtask

  task automatic scan(input logic [15:0] din, input bit do_cap, input bit do_upd,
                      input int delay, input logic [7:0] rd, output logic [15:0] dout);
    tick();
    captureuser = do_cap;
    if (do_cap) begin
      m_frame = {1'b1, m_seq, m_ovr, m_err, m_busy, m_rdata};
      m_err = 0; m_ovr = 0;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      captureuser = 1'b0;
      dout[i] = tdouser;
      shiftuser = 1'b1;
      tdiutap = din[i];
    end
    tick();
    shiftuser = 1'b0;
    if (do_upd) issue_update(din, delay, rd);
    tick();
    updateuser = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [15:0] f;

  initial begin
    vecs[0] = '{16'h8A5C, 1, 3,  8'h00, 16'h8000, "write"};
    vecs[1] = '{16'h0300, 1, 2,  8'hC3, 16'h8800, "read"};
    vecs[2] = '{16'h0255, 1, 0,  8'hEE, 16'h90C3, "timeout"};
    vecs[3] = '{16'h0000, 1, 1,  8'h11, 16'h92C3, "err_set"};
    vecs[4] = '{16'h8000, 1, 15, 8'h00, 16'h9811, "err_clear"};
    vecs[5] = '{16'h0000, 0, 0,  8'h00, 16'hA011, "ack_at_timeout"};

    reset = 1'b1; usr1user = 1'b1; captureuser = 0; shiftuser = 0;
    updateuser = 0; tdiutap = 0;
    model_reset();
    #3;
    check(bif.bus_req === 0 && bif.bus_we === 0 && busy === 0 && bif.bus_addr === 0 &&
          bif.bus_wdata === 0 && tdouser === 0, "reset_state",
          {bif.bus_req, bif.bus_we, busy, bif.bus_addr, bif.bus_wdata, tdouser}, 0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // Directed table.
    foreach (vecs[i]) begin
      scan(vecs[i].cmd, 1, vecs[i].do_upd, vecs[i].delay, vecs[i].rd, f);
      check(f === vecs[i].exp_frame, vecs[i].name, f, vecs[i].exp_frame);
      idle(20);
    end

    // Overrun: a second Update while the read is outstanding.
    scan(16'h1775, 1, 1, 10, 8'h5A, f);
    check(f === 16'hA011, "ovr_pre", f, 16'hA011);
    for (int i = 0; i < 4; i++) begin
      tick();
      shiftuser = 1'b1;
      tdiutap = (i == 3);
    end
    tick();
    shiftuser = 1'b0;
    issue_update(16'h8177, 1, 8'h00);
    tick();
    updateuser = 1'b0;
    idle(20);
    scan(16'h0000, 1, 0, 0, 8'h00, f);
    check(f === 16'hAC5A, "overrun", f, 16'hAC5A);
    scan(16'h0000, 1, 0, 0, 8'h00, f);
    check(f === 16'hA85A, "overrun_cleared", f, 16'hA85A);

    // Deselected: strobes and TDI must leave sr and the bus untouched.
    scan(16'h1234, 0, 0, 0, 8'h00, f);
    usr1user = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      captureuser = 1'($urandom);
      shiftuser   = 1'($urandom);
      updateuser  = 1'($urandom);
      tdiutap     = 1'($urandom);
    end
    tick();
    captureuser = 0; shiftuser = 0; updateuser = 0;
    usr1user = 1'b1;
    scan(16'h0000, 0, 0, 0, 8'h00, f);
    check(f === 16'h1234, "deselected_sr", f, 16'h1234);

    // Randomized transactions against the model.
    for (int it = 0; it < 60; it++) begin
      logic [15:0] cmd;
      cmd = 16'($urandom);
      scan(cmd, 1, 1, $urandom_range(0, 18), 8'($urandom), f);
      check(f === m_frame, "random_frame", f, m_frame);
      idle($urandom_range(0, 22));
    end
    idle(20);
    scan(16'h0000, 1, 0, 0, 8'h00, f);
    check(f === m_frame, "random_final", f, m_frame);

    // Reset in the middle of a transaction.
    scan(16'h0042, 1, 1, 0, 8'h00, f);
    idle(3);
    check(bif.bus_req === 1'b1, "pre_reset_req", bif.bus_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check(bif.bus_req === 0 && busy === 0 && tdouser === 0, "async_reset",
          {bif.bus_req, busy, tdouser}, 0);
    model_reset();
    idle(2);
    reset = 1'b0;
    idle(2);
    scan(16'h0000, 1, 0, 0, 8'h00, f);
    check(f === 16'h8000, "post_reset_frame", f, 16'h8000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
